// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Multi-channel reset sequencer. Holds every active-low reset output low for
// at least HOLD_CYCLES cycles. Once the synchronized clock-source lock is
// seen, it releases the outputs one at a time, channel 0 first, STAGE_DELAY
// cycles apart. Any request (external, software) or a lock loss after release
// has begun drops every output together and restarts the whole sequence.
// The cause of the most recent entry into the ASSERT state is recorded.
//
// Ports
//   clk          in   system clock
//   reset        in   block reset, synchronous, active-high
//   ext_rst_req  in   external reset request, asynchronous, active-high
//   sw_rst_req   in   software reset request, synchronous, active-high
//   locked       in   clock-source lock, asynchronous
//   rst_out_n    out  [NUM_OUT-1:0] per-domain resets, active-low
//   ready        out  high once every channel is released
//   state        out  00 ASSERT, 01 WAIT_LOCK, 10 RELEASE, 11 RUN
//   cause        out  [0] reset, [1] ext, [2] sw, [3] lock loss
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int NUM_OUT     = 3,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_DELAY = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ext_rst_req,
  input  logic               sw_rst_req,
  input  logic               locked,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               ready,
  output logic [1:0]         state,
  output logic [3:0]         cause
);

  localparam int MAX_DLY = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
  localparam int CNT_W   = $clog2(MAX_DLY + 1);
  localparam int IDX_W   = $clog2(NUM_OUT + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'b00,
    ST_WAIT_LOCK = 2'b01,
    ST_RELEASE   = 2'b10,
    ST_RUN       = 2'b11
  } state_t;

  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [IDX_W-1:0]         r_idx;
  logic [NUM_OUT-1:0]       r_rst_out_n;
  logic                     r_ready;
  logic [3:0]               r_cause;
  logic [SYNC_STAGES-1:0]   r_ext_sync;
  logic [SYNC_STAGES-1:0]   r_lock_sync;

  logic w_ext_sync;
  logic w_lock_s;
  logic w_req;
  logic w_active;
  logic w_lock_lost;
  logic w_abort;

  assign w_ext_sync  = r_ext_sync[SYNC_STAGES-1];
  assign w_lock_s    = r_lock_sync[SYNC_STAGES-1];
  assign w_req       = w_ext_sync | sw_rst_req;
  // Lock loss only counts once release has begun; in WAIT_LOCK it just waits.
  assign w_active    = (r_state == ST_RELEASE) || (r_state == ST_RUN);
  assign w_lock_lost = w_active & ~w_lock_s;
  assign w_abort     = w_req | w_lock_lost;

  // ext_rst_req and locked come from other clock domains; plain flop chains
  // bring them into clk before the FSM ever looks at them.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // which is what makes the chains below real shift registers.
    if (reset) begin
      r_ext_sync  <= '0;
      r_lock_sync <= '0;
    end else begin
      r_ext_sync  <= {r_ext_sync[SYNC_STAGES-2:0], ext_rst_req};
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], locked};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_ASSERT;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rst_out_n <= '0;
      r_ready     <= 1'b0;
      r_cause     <= 4'b0001;
    end else if ((r_state != ST_ASSERT) && w_abort) begin
      // Every channel drops on the same edge; cause is captured only here.
      r_state     <= ST_ASSERT;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rst_out_n <= '0;
      r_ready     <= 1'b0;
      r_cause     <= {w_lock_lost, sw_rst_req, w_ext_sync, 1'b0};
    end else begin
      case (r_state)
        ST_ASSERT: begin
          if (w_req) begin
            r_cnt <= '0;
          end else if (r_cnt == HOLD_LAST) begin
            r_state <= ST_WAIT_LOCK;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (w_lock_s) begin
            r_state <= ST_RELEASE;
            r_cnt   <= '0;
            r_idx   <= '0;
          end
        end
        ST_RELEASE: begin
          if (r_cnt == STAGE_LAST) begin
            // Shifting a 1 in from the bottom releases channel r_idx and keeps
            // the released channels a contiguous prefix from channel 0.
            r_rst_out_n <= (r_rst_out_n << 1) | NUM_OUT'(1);
            r_cnt       <= '0;
            r_idx       <= r_idx + IDX_W'(1);
            if (r_idx == IDX_LAST) begin
              r_state <= ST_RUN;
              r_ready <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          // RUN: everything held until an abort.
        end
      endcase
    end
  end

  assign rst_out_n = r_rst_out_n;
  assign ready     = r_ready;
  assign state     = r_state;
  assign cause     = r_cause;

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset sequencer generating NUM_OUT active-low reset outputs that are held for a minimum time and then released one at a time, in fixed order, once the clock source reports lock. Sits at the top of the design between the board clock/reset inputs and the CPU pipeline, memory and peripheral reset domains. It is the multi-channel successor of the single-output power-on reset delay. It adds an external-request synchronizer, a software reset request, lock monitoring and a reset-cause record.

## Interface
- NUM_OUT, 3: number of reset outputs; channel 0 released first; ≥1
- HOLD_CYCLES, 8: minimum cycles all outputs stay asserted; ≥1
- STAGE_DELAY, 4: cycles between successive channel releases; ≥1
- SYNC_STAGES, 2: flop stages on ext_rst_req and locked; ≥2

- clk  in  1  system clock
- reset  in  1  block reset; synchronous, active-high
- ext_rst_req  in  1  external reset request, asynchronous, active-high; SYNC_STAGES-synchronized
- sw_rst_req  in  1  software reset request, synchronous, active-high; level or pulse
- locked  in  1  clock-source lock, asynchronous; SYNC_STAGES-synchronized
- rst_out_n  out  NUM_OUT  per-domain reset, active-low
- ready  out  1  high when all channels released
- state  out  2  00 ASSERT, 01 WAIT_LOCK, 10 RELEASE, 11 RUN
- cause  out  4  last reset cause: [0] POR/reset, [1] ext, [2] sw, [3] lock loss

## Operation
- All registers update on the rising edge of clk. Counter width is clog2(max(HOLD_CYCLES, STAGE_DELAY)+1); channel index width is clog2(NUM_OUT+1).
- req = ext_sync | sw_rst_req. lock_s = synchronized locked.
- reset high, with priority over everything else: state=ASSERT, cnt=0, idx=0, rst_out_n=all 0, ready=0, cause=4'b0001. Synchronizer flops are cleared to 0.
- ASSERT: all outputs 0.
  - req: cnt=0, stay in ASSERT.
  - Otherwise, if cnt==HOLD_CYCLES-1: go to WAIT_LOCK.
  - Otherwise: cnt++.
- WAIT_LOCK: all outputs 0.
  - req: go to ASSERT.
  - Otherwise, if lock_s: go to RELEASE with cnt=0, idx=0.
- RELEASE:
  - If cnt==STAGE_DELAY-1: rst_out_n[idx]<=1, cnt=0, idx++. If idx==NUM_OUT-1, go to RUN and set ready<=1 on the same edge.
  - Otherwise: cnt++.
- RUN: outputs held; all bits of rst_out_n are 1; ready=1.
- Abort, from WAIT_LOCK, RELEASE or RUN: req, or !lock_s in RELEASE/RUN.
  - Next edge: state=ASSERT, cnt=0, idx=0, rst_out_n=all 0, ready=0.
  - All channels re-assert together. Released channels never re-assert one at a time.
- cause is loaded only on an edge that enters ASSERT from another state, or on reset. It is the OR of all sources active at that edge: [1]=ext_sync, [2]=sw_rst_req, [3]=!lock_s while in RELEASE/RUN.
- A req that repeats while already in ASSERT only restarts cnt; cause is unchanged. cause holds until the next entry into ASSERT.
- Released channels form a prefix: rst_out_n[k]=1 implies rst_out_n[j]=1 for all j<k.

## Timing
- Edge 0 is the last edge at which reset is sampled high, with lock_s high and no req afterwards.
  - WAIT_LOCK is entered at edge HOLD_CYCLES.
  - RELEASE is entered at edge HOLD_CYCLES+1.
  - Channel k is released at edge HOLD_CYCLES+1+(k+1)*STAGE_DELAY.
  - ready rises on the same edge as channel NUM_OUT-1.
- Edge counts must match exactly.
- ext_rst_req and locked each see SYNC_STAGES cycles of latency before acting. sw_rst_req acts on the edge it is sampled.
- Abort latency: one edge from the sampled condition to all outputs low.
- A 1-cycle sw_rst_req pulse is sufficient to trigger a full sequence, including the HOLD_CYCLES minimum hold.
- lock_s low in WAIT_LOCK: stay in WAIT_LOCK indefinitely; not an abort, no cause update.

## Test plan
- Defaults (NUM_OUT=3, HOLD=8, STAGE=4); reset high then low; locked=1 settled -> rst_out_n 001 at edge 13, 011 at 17, 111 at 21; ready=1 at 21; cause=0001.
- locked=0 through reset release, raised at cycle 30 -> state stays 01 until lock_s rises at cycle 32; RELEASE entered next edge; ch0 released 4 cycles later.
- In RUN, 1-cycle sw_rst_req -> next edge rst_out_n=000, ready=0, cause=0100, state=00; full sequence repeats with the same 8/+1/+4k timing.
- ext_rst_req held high for 20 cycles during RELEASE (one channel already released) -> all outputs low 2+1 edges after assertion; state stays ASSERT with cnt=0 while held; hold runs 8 cycles after ext_sync drops; cause=0010.
- locked drops in RUN -> abort, cause=1000. locked drops and sw_rst_req asserts on the same sampled edge -> cause=1100.
- Parameter sweep (NUM_OUT=1, HOLD=1, STAGE=1; then NUM_OUT=8) -> edge formula holds, prefix ordering holds, ready coincides with the last release. reset asserted mid-RELEASE -> next edge equals the reset state.
